fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage with a prefetch queue. It sits directly upstream of the instruction decoder. It issues word reads to instruction memory from a private fetch PC and buffers the returned words with their addresses. It presents them to the decoder through a valid/ready handshake, and flushes and redirects on a branch.

## Interface
- DEPTH, 4, number of queue entries; power of two, at least 2
- RESET_PC, 32'h0000_0000, first fetch address; bits [1:0] must be 0
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_req  out  1  read request to instruction memory
- mem_addr  out  32  word address of the request; bits [1:0] always 0
- mem_ack  in  1  completes the request in the cycle where mem_req and mem_ack are both high
- mem_rdata  in  32  read data; valid only with mem_ack
- branch_valid  in  1  one-cycle redirect pulse
- branch_target  in  32  redirect address; bits [1:0] are ignored and forced to 0
- instr_valid  out  1  queue head is valid
- instr  out  32  instruction word at the queue head
- instr_pc  out  32  address the head word was fetched from
- instr_ready  in  1  decoder consumes the head when instr_valid and instr_ready are both high

## Operation
- Queue: DEPTH-entry circular buffer of {word, pc}, with read pointer, write pointer and count (width log2(DEPTH)+1).
  - instr_valid = (count != 0).
  - instr and instr_pc come combinationally from the head entry.
- At most one memory request is outstanding.
  - mem_addr is held stable while mem_req is high until the ack.
  - A request is issued only when count < DEPTH, so an accepted response always has space.
- fetch_pc advances by +4, modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- mem_req is high in states FETCH and DRAIN.
- IDLE (no request):
  - branch_valid: flush the queue, set fetch_pc and mem_addr to the target, go to FETCH.
  - Otherwise, if count < DEPTH: set mem_addr = fetch_pc, go to FETCH.
- FETCH:
  - ack without branch: push {mem_rdata, mem_addr}; fetch_pc = mem_addr + 4.
    - If the post-push/pop count < DEPTH: mem_addr = mem_addr + 4 and stay in FETCH (back-to-back).
    - Otherwise go to IDLE.
  - ack with branch: drop the response, flush, mem_addr = fetch_pc = target, stay in FETCH.
  - branch without ack: flush, fetch_pc = target, go to DRAIN. mem_addr keeps the old address.
- DRAIN (waiting out the stale request):
  - ack: drop the response, mem_addr = fetch_pc, go to FETCH.
  - branch: update fetch_pc to the new target. This also applies in the same cycle as an ack; the newest target wins.
- Flush priority: flush beats push and pop in the same cycle. A pop at a flush edge is discarded with the rest of the queue; the decoder must treat its own branch as squashing that handshake.
- Push and pop in the same cycle without a flush: count is unchanged and both pointers advance.
- The queue is never written when full and never read when empty. Pointers wrap modulo DEPTH.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, mem_req = 0, mem_addr = RESET_PC, fetch_pc = RESET_PC.
  - count = 0, pointers = 0, instr_valid = 0.
  - All queue entries are 0, so instr = 0 and instr_pc = 0.
- First edge after rst_n rises: IDLE to FETCH. mem_req is high in the first cycle after that edge.
- Load-to-use: ack sampled at edge N, so instr_valid is high after edge N, and the decoder can consume at edge N+1.
- Throughput is 1 word per cycle with a zero-wait memory and continuous instr_ready.
- Branch to first new instruction:
  - With no request outstanding (IDLE, or FETCH with an ack in the branch cycle): the new request is issued the cycle after the branch edge.
  - Otherwise the branch passes through DRAIN, which adds one cycle per stale wait state.
- Reset mid-request: the outstanding request is abandoned. Memory must tolerate mem_req dropping without an ack.

## Test plan
- Zero-wait memory (ack tied high), instr_ready = 1, RESET_PC = 0: instr_pc sequence 0, 4, 8, C on consecutive cycles; one instr_valid cycle per word; mem_addr matches mem_rdata order.
- instr_ready = 0, DEPTH = 4: after 4 acks, count = 4, state = IDLE, mem_req = 0. Raise ready for 1 cycle: mem_req reasserts next cycle at address 0x10.
- Memory with 3 wait states; branch_valid with target 0x103 asserted in the second wait cycle: the stale word is dropped, the queue is empty, and the next mem_addr is 0x100. The first instr_pc after the redirect is 0x100.
- branch_valid in the same cycle as an ack and a pop with 2 entries queued: count becomes 0, the ack data never appears, and the next mem_addr is the target.
- RESET_PC = 0xFFFF_FFF8, zero-wait memory: instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert rst_n low mid-FETCH with a 2-entry queue: mem_req, instr_valid and count go to 0 immediately, without waiting for a clock edge. Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a prefetch queue and branch redirect
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   mem_req, mem_addr              word read request to instruction memory
//   mem_ack, mem_rdata             request completion and read data
//   branch_valid, branch_target    one-cycle redirect pulse and target
//   instr_valid, instr, instr_pc   queue head presented to the decoder
//   instr_ready                    decoder consumes the head
module fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        branch_valid,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   q_word [DEPTH];
    logic [31:0]   q_pc   [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count, count_nx;
    logic          ack, pop, push;
    logic [31:0]   tgt;

    always_comb begin
        ack         = mem_req && mem_ack;
        pop         = instr_valid && instr_ready;
        // responses are only kept in FETCH; a branch in the same cycle drops them
        push        = state == FETCH && ack && !branch_valid;
        tgt         = branch_target & ~32'h3;
        count_nx    = branch_valid ? '0 : count + CW'(push) - CW'(pop);
        instr_valid = count != '0;
        instr       = q_word[rd_ptr];
        instr_pc    = q_pc[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_word[i] <= '0;
                q_pc[i]   <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                q_word[wr_ptr] <= mem_rdata;
                q_pc[wr_ptr]   <= mem_addr;
            end
            rd_ptr <= branch_valid ? '0 : rd_ptr + PW'(pop);
            wr_ptr <= branch_valid ? '0 : wr_ptr + PW'(push);
            count  <= count_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (branch_valid) begin
                        fetch_pc <= tgt;
                        mem_addr <= tgt;
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                    end else if (count < FULL) begin
                        mem_addr <= fetch_pc;
                        state    <= FETCH;
                        mem_req  <= 1'b1;
                    end
                end
                FETCH: begin
                    if (ack && branch_valid) begin
                        mem_addr <= tgt;
                        fetch_pc <= tgt;
                    end else if (ack) begin
                        fetch_pc <= mem_addr + 32'd4;
                        if (count_nx < FULL) begin
                            mem_addr <= mem_addr + 32'd4;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end else if (branch_valid) begin
                        // the old request stays on the bus until memory answers it
                        fetch_pc <= tgt;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (branch_valid) fetch_pc <= tgt;
                    if (ack) begin
                        mem_addr <= branch_valid ? tgt : fetch_pc;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit with a queue-level reference model
module tb_fetch_unit;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_req, mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_rdata;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    logic        req1, valid1;
    logic [31:0] addr1, rdata1, instr1, pc1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int waits = 0;
    int wcnt = 0;

    ent_t        mq[$];
    logic [31:0] exp_pc = 32'h0;
    bit          stale = 0;
    bit          pend = 0;
    logic [31:0] pend_addr = 32'h0;
    logic [31:0] wrap_pc [3] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
    endfunction

    assign mem_rdata = word_at(mem_addr);
    assign rdata1    = word_at(addr1);

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u0 (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .branch_valid(branch_valid), .branch_target(branch_target),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst_n(rst_n),
        .mem_req(req1), .mem_addr(addr1), .mem_ack(1'b1), .mem_rdata(rdata1),
        .branch_valid(1'b0), .branch_target(32'h0),
        .instr_valid(valid1), .instr(instr1), .instr_pc(pc1), .instr_ready(1'b1)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // memory with a programmable number of wait states per request
    always @(posedge clk) begin
        #1;
        mem_ack = mem_req && wcnt >= waits;
        wcnt = mem_req ? (mem_ack ? 0 : wcnt + 1) : 0;
    end

    // reference model: queue contents follow accepted responses, pops and flushes
    always @(negedge clk) begin
        logic ack, pop;
        if (!rst_n) begin
            chk("rst_req", mem_req, 32'd0);
            chk("rst_addr", mem_addr, 32'h0);
            chk("rst_valid", instr_valid, 32'd0);
            chk("rst_instr", instr, 32'h0);
            chk("rst_pc", instr_pc, 32'h0);
            mq.delete();
            exp_pc = 32'h0;
            stale = 0;
            pend = 0;
        end else begin
            chk("valid", instr_valid, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("instr", instr, mq[0].w);
                chk("pc", instr_pc, mq[0].pc);
            end
            chk("addr_align", mem_addr[1:0], 32'd0);
            if (pend && mem_req) chk("addr_hold", mem_addr, pend_addr);
            if (mem_req && !pend) chk("issue_room", mq.size() < DEPTH, 32'd1);
            ack = mem_req && mem_ack;
            pop = instr_valid && instr_ready;
            pend = mem_req && !ack;
            pend_addr = mem_addr;
            if (branch_valid) begin
                mq.delete();
                exp_pc = branch_target & ~32'h3;
                stale = pend;
            end else begin
                if (pop && mq.size() != 0) void'(mq.pop_front());
                if (ack && stale) stale = 0;
                else if (ack) begin
                    chk("fetch_addr", mem_addr, exp_pc);
                    mq.push_back('{mem_rdata, mem_addr});
                    exp_pc += 32'd4;
                    chk("occupancy", mq.size() <= DEPTH, 32'd1);
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int bound);
        for (int i = 0; i < bound && !instr_valid; i++) begin
            @(posedge clk);
            #2;
        end
        chk(name, instr_valid, 32'd1);
    endtask

    task automatic wait_addr(input string name, input logic [31:0] a, input int bound);
        for (int i = 0; i < bound && mem_addr != a; i++) begin
            @(posedge clk);
            #2;
        end
        chk(name, mem_addr, a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        branch_valid  = 1'b0;
        branch_target = 32'h0;
        instr_ready   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_u1_addr", addr1, 32'hFFFF_FFF8);
        chk("rst_u1_req", req1, 32'd0);
        chk("rst_u1_valid", valid1, 32'd0);
        rst_n = 1'b1;

        // zero-wait streaming, plus address wrap on the second instance
        wait_valid("t1_first", 10);
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", instr_valid, 32'd1);
            chk("t1_pc", instr_pc, 32'(4 * i));
            chk("t1_word", instr, word_at(32'(4 * i)));
            if (i < 3) begin
                chk("t5_valid", valid1, 32'd1);
                chk("t5_pc", pc1, wrap_pc[i]);
            end
            @(posedge clk);
            #2;
        end

        // queue fills with the decoder stalled, then one pop re-enables fetch
        instr_ready = 1'b0;
        do_reset();
        repeat (8) @(posedge clk);
        #2;
        chk("t2_req_off", mem_req, 32'd0);
        chk("t2_valid", instr_valid, 32'd1);
        chk("t2_head", instr_pc, 32'h0);
        instr_ready = 1'b1;
        @(posedge clk);
        #1 instr_ready = 1'b0;
        for (int i = 0; i < 5 && !mem_req; i++) begin
            @(posedge clk);
            #2;
        end
        chk("t2_req_on", mem_req, 32'd1);
        chk("t2_addr", mem_addr, 32'h10);
        chk("t2_head_next", instr_pc, 32'h4);

        // branch in the second wait cycle of a 3-wait-state request
        instr_ready = 1'b1;
        waits = 3;
        do_reset();
        for (int i = 0; i < 5 && !mem_req; i++) begin
            @(posedge clk);
            #2;
        end
        chk("t3_req", mem_req, 32'd1);
        @(posedge clk);
        #2;
        branch_valid  = 1'b1;
        branch_target = 32'h103;
        @(posedge clk);
        #2;
        branch_valid = 1'b0;
        chk("t3_flushed", instr_valid, 32'd0);
        chk("t3_stale_addr", mem_addr, 32'h0);
        chk("t3_stale_req", mem_req, 32'd1);
        for (int i = 0; i < 10 && mem_addr == 32'h0; i++) begin
            @(posedge clk);
            #2;
        end
        chk("t3_new_addr", mem_addr, 32'h100);
        wait_valid("t3_first", 15);
        chk("t3_pc", instr_pc, 32'h100);
        chk("t3_word", instr, word_at(32'h100));

        // branch together with an ack and a pop while two entries are queued
        waits = 0;
        instr_ready = 1'b0;
        do_reset();
        wait_addr("t4_two_queued", 32'h8, 10);
        branch_valid  = 1'b1;
        branch_target = 32'h200;
        instr_ready   = 1'b1;
        @(posedge clk);
        #2;
        branch_valid = 1'b0;
        chk("t4_empty", instr_valid, 32'd0);
        chk("t4_addr", mem_addr, 32'h200);
        chk("t4_req", mem_req, 32'd1);
        @(posedge clk);
        #2;
        chk("t4_valid", instr_valid, 32'd1);
        chk("t4_pc", instr_pc, 32'h200);

        // asynchronous reset in the middle of a fetch with two entries queued
        instr_ready = 1'b0;
        do_reset();
        wait_addr("t6_two_queued", 32'h8, 10);
        chk("t6_pre_valid", instr_valid, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_req", mem_req, 32'd0);
        chk("t6_valid", instr_valid, 32'd0);
        chk("t6_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        instr_ready = 1'b1;
        wait_valid("t6_restart", 10);
        chk("t6_pc", instr_pc, 32'h0);

        // mixed traffic: one wait state, intermittent stalls, two redirects
        waits = 1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            instr_ready   = (i % 3) != 0;
            branch_valid  = i == 20 || i == 41;
            branch_target = i == 20 ? 32'h3FE : 32'h40;
        end
        @(posedge clk);
        #1 branch_valid = 1'b0;
        repeat (10) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
